// File: rtl/cbfp_pkg.sv
// rtl/cbfp_pkg.sv - shared types and defaults for the CBFP frame sequencer
// Holds the sequencer state encoding, default frame geometry and timeout,
// the exponent-table address width and the 5-bit block-exponent type.
package cbfp_pkg;

    localparam int FRAME_CYC_DEF = 32;
    localparam int BLK_CYC_DEF   = 4;
    localparam int TMO_CYC_DEF   = 127;
    localparam int IDX_AW        = 3;

    typedef logic [4:0] exp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cbfp_seq_if.sv
// rtl/cbfp_seq_if.sv - signal bundle between the CBFP sequencer and its environment
// Ports (slave = sequencer view):
//   in : start, src_valid, cbfp_do_en, cbfp_index, err_clr
//   out: cbfp_di_en, idx_we, idx_addr, idx_data, busy, frame_done,
//        frame_cnt, err_gap, err_tmo
interface cbfp_seq_if;
    import cbfp_pkg::*;

    logic              start;
    logic              src_valid;
    logic              cbfp_di_en;
    logic              cbfp_do_en;
    exp_t              cbfp_index;
    logic              idx_we;
    logic [IDX_AW-1:0] idx_addr;
    exp_t              idx_data;
    logic              busy;
    logic              frame_done;
    logic [7:0]        frame_cnt;
    logic              err_gap;
    logic              err_tmo;
    logic              err_clr;

    modport slave (
        input  start, src_valid, cbfp_do_en, cbfp_index, err_clr,
        output cbfp_di_en, idx_we, idx_addr, idx_data, busy, frame_done,
               frame_cnt, err_gap, err_tmo
    );

    modport master (
        output start, src_valid, cbfp_do_en, cbfp_index, err_clr,
        input  cbfp_di_en, idx_we, idx_addr, idx_data, busy, frame_done,
               frame_cnt, err_gap, err_tmo
    );

endinterface

// File: rtl/cbfp_seq.sv
// rtl/cbfp_seq.sv - frame sequencer feeding a CBFP stage and logging block exponents
// Ports: clk, rstn (async, active-low), bus (cbfp_seq_if.slave).
// Feeds FRAME_CYC cycles of upstream data into the CBFP stage, then counts
// the stage's output cycles and writes one exponent per BLK_CYC-cycle block
// into the exponent table. Gaps in upstream data and a stalled drain are
// flagged with sticky error bits and abort the frame.
module cbfp_seq
    import cbfp_pkg::*;
#(
    parameter int FRAME_CYC = FRAME_CYC_DEF,
    parameter int BLK_CYC   = BLK_CYC_DEF,
    parameter int TMO_CYC   = TMO_CYC_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    cbfp_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(FRAME_CYC);
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TMO_CYC);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  feed_cnt_q, feed_cnt_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              di_en_q, di_en_d;
    logic              idx_we_q, idx_we_d;
    logic [IDX_AW-1:0] idx_addr_q, idx_addr_d;
    exp_t              idx_data_q, idx_data_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              err_gap_q, err_gap_d;
    logic              err_tmo_q, err_tmo_d;

    always_comb begin
        state_d      = state_q;
        feed_cnt_d   = feed_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        di_en_d      = 1'b0;
        idx_we_d     = 1'b0;
        idx_addr_d   = idx_addr_q;
        idx_data_d   = idx_data_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        // Clear first so that a same-cycle error set below takes priority.
        err_gap_d    = err_gap_q & ~bus.err_clr;
        err_tmo_d    = err_tmo_q & ~bus.err_clr;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && bus.src_valid) begin
                    state_d    = ST_FEED;
                    feed_cnt_d = '0;
                    di_en_d    = 1'b1;
                end
            end
            ST_FEED: begin
                if (!bus.src_valid) begin
                    err_gap_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (feed_cnt_q == CNT_LAST) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                    tmo_cnt_d   = '0;
                end else begin
                    feed_cnt_d = feed_cnt_q + 1'b1;
                    di_en_d    = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bus.cbfp_do_en) begin
                    tmo_cnt_d = '0;
                    // First output cycle of each block carries that block's exponent.
                    if ((32'(drain_cnt_q) % BLK_CYC) == 0) begin
                        idx_we_d   = 1'b1;
                        idx_addr_d = IDX_AW'(32'(drain_cnt_q) / BLK_CYC);
                        idx_data_d = bus.cbfp_index;
                    end
                    if (drain_cnt_q == CNT_LAST) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (tmo_cnt_d == TMO_LIM) begin
                        err_tmo_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            feed_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            tmo_cnt_q    <= '0;
            di_en_q      <= 1'b0;
            idx_we_q     <= 1'b0;
            idx_addr_q   <= '0;
            idx_data_q   <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            err_gap_q    <= 1'b0;
            err_tmo_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            feed_cnt_q   <= feed_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            di_en_q      <= di_en_d;
            idx_we_q     <= idx_we_d;
            idx_addr_q   <= idx_addr_d;
            idx_data_q   <= idx_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            err_gap_q    <= err_gap_d;
            err_tmo_q    <= err_tmo_d;
        end
    end

    assign bus.cbfp_di_en = di_en_q;
    assign bus.idx_we     = idx_we_q;
    assign bus.idx_addr   = idx_addr_q;
    assign bus.idx_data   = idx_data_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.frame_done = frame_done_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.err_gap    = err_gap_q;
    assign bus.err_tmo    = err_tmo_q;

endmodule

// File: tb/tb_cbfp_seq.sv
// tb/tb_cbfp_seq.sv - self-checking bench for cbfp_seq
module tb_cbfp_seq;

    localparam int FRAME = 32;
    localparam int BLK   = 4;
    localparam int NBLK  = FRAME / BLK;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    int   exp_fc;

    logic [2:0] wr_addr[$];
    logic [4:0] wr_data[$];
    int         done_pulses;
    int         di_pulses;

    logic [4:0] exp_data[NBLK];
    int         wr_base;
    int         done_base;
    int         di_base;

    cbfp_seq_if bus();

    cbfp_seq dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.idx_we) begin
                wr_addr.push_back(bus.idx_addr);
                wr_data.push_back(bus.idx_data);
            end
            if (bus.frame_done) done_pulses++;
            if (bus.cbfp_di_en) di_pulses++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame: start, feed until di_en falls, wait pre_gap, then
    // FRAME output cycles with optional gaps. Expected exponents are the
    // values presented on the first output cycle of each block.
    task automatic run_frame(input int pre_gap, input int gap_after, input int gap_len,
                             input bit rnd_vals, input bit rnd_gaps);
        int n;
        logic [4:0] v;
        wr_base   = wr_addr.size();
        done_base = done_pulses;
        di_base   = di_pulses;
        bus.start     = 1'b1;
        bus.src_valid = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (bus.cbfp_di_en && n < 100) begin
            step();
            n++;
        end
        repeat (pre_gap) step();
        for (int c = 0; c < FRAME; c++) begin
            if (c % BLK == 0) begin
                v = rnd_vals ? 5'($urandom) : 5'(c / BLK + 10);
                exp_data[c / BLK] = v;
            end else begin
                v = 5'($urandom);
            end
            bus.cbfp_do_en = 1'b1;
            bus.cbfp_index = v;
            step();
            bus.cbfp_do_en = 1'b0;
            bus.cbfp_index = 5'($urandom);
            if (c == gap_after) repeat (gap_len) step();
            else if (rnd_gaps) repeat ($urandom_range(0, 3)) step();
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rstn           = 1'b0;
        bus.start      = 1'b0;
        bus.src_valid  = 1'b0;
        bus.cbfp_do_en = 1'b0;
        bus.cbfp_index = '0;
        bus.err_clr    = 1'b0;
        exp_fc         = 0;
        repeat (3) step();
        checks++;
        if ({bus.cbfp_di_en, bus.idx_we, bus.frame_done, bus.busy, bus.err_gap, bus.err_tmo} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {bus.cbfp_di_en, bus.idx_we, bus.frame_done, bus.busy, bus.err_gap, bus.err_tmo});
        end
        checks++;
        if ({bus.idx_addr, bus.idx_data, bus.frame_cnt} !== 16'h0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0", {bus.idx_addr, bus.idx_data, bus.frame_cnt});
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_good_frame();
        for (int r = 0; r < 2; r++) begin
            if (r == 0) run_frame(6, -1, 0, 1'b0, 1'b0);
            else        run_frame($urandom_range(0, 20), -1, 0, 1'b1, 1'b1);
            exp_fc++;
            checks++;
            if (di_pulses - di_base != FRAME) begin
                errors++;
                $display("FAIL good_di_len: got %0d expected %0d", di_pulses - di_base, FRAME);
            end
            checks++;
            if (wr_addr.size() - wr_base != NBLK) begin
                errors++;
                $display("FAIL good_wr_count: got %0d expected %0d", wr_addr.size() - wr_base, NBLK);
            end
            for (int b = 0; b < NBLK && wr_base + b < wr_addr.size(); b++) begin
                checks++;
                if (wr_addr[wr_base + b] !== 3'(b) || wr_data[wr_base + b] !== exp_data[b]) begin
                    errors++;
                    $display("FAIL good_wr[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                             b, wr_addr[wr_base + b], wr_data[wr_base + b], b, exp_data[b]);
                end
            end
            checks++;
            if (done_pulses - done_base != 1 || bus.frame_cnt !== 8'(exp_fc) || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL good_done: got pulses %0d cnt %0d busy %b expected 1 %0d 0",
                         done_pulses - done_base, bus.frame_cnt, bus.busy, exp_fc);
            end
        end
    endtask

    task automatic test_gap();
        int base;
        int d0;
        int k;
        base = wr_addr.size();
        d0   = done_pulses;
        bus.start     = 1'b1;
        bus.src_valid = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (10) step();
        bus.src_valid = 1'b0;
        step();
        checks++;
        if (bus.err_gap !== 1'b1 || bus.cbfp_di_en !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL gap_abort: got err_gap %b di_en %b busy %b expected 1 0 0",
                     bus.err_gap, bus.cbfp_di_en, bus.busy);
        end
        bus.src_valid = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.frame_cnt !== 8'(exp_fc) || done_pulses != d0 || wr_addr.size() != base) begin
            errors++;
            $display("FAIL gap_no_side_effect: got cnt %0d pulses %0d writes %0d expected %0d 0 0",
                     bus.frame_cnt, done_pulses - d0, wr_addr.size() - base, exp_fc);
        end
        run_frame(6, -1, 0, 1'b1, 1'b0);
        exp_fc++;
        checks++;
        if (done_pulses - done_base != 1 || bus.frame_cnt !== 8'(exp_fc) || bus.err_gap !== 1'b1
            || wr_addr.size() - wr_base != NBLK) begin
            errors++;
            $display("FAIL gap_next_frame: got pulses %0d cnt %0d err_gap %b writes %0d expected 1 %0d 1 %0d",
                     done_pulses - done_base, bus.frame_cnt, bus.err_gap, wr_addr.size() - wr_base, exp_fc, NBLK);
        end
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err_gap !== 1'b0) begin
            errors++;
            $display("FAIL gap_clear: got %b expected 0", bus.err_gap);
        end
        k = $urandom_range(0, FRAME - 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (k) step();
        bus.src_valid = 1'b0;
        bus.err_clr   = 1'b1;
        step();
        bus.src_valid = 1'b1;
        bus.err_clr   = 1'b0;
        checks++;
        if (bus.err_gap !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL gap_set_wins(k=%0d): got err_gap %b busy %b expected 1 0", k, bus.err_gap, bus.busy);
        end
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
    endtask

    task automatic test_do_gap();
        for (int r = 0; r < 2; r++) begin
            if (r == 0) run_frame(6, 12, 3, 1'b0, 1'b0);
            else        run_frame(0, 20, 126, 1'b1, 1'b0);
            exp_fc++;
            checks++;
            if (wr_addr.size() - wr_base != NBLK) begin
                errors++;
                $display("FAIL dogap_wr_count(r=%0d): got %0d expected %0d", r, wr_addr.size() - wr_base, NBLK);
            end
            for (int b = 0; b < NBLK && wr_base + b < wr_addr.size(); b++) begin
                checks++;
                if (wr_addr[wr_base + b] !== 3'(b) || wr_data[wr_base + b] !== exp_data[b]) begin
                    errors++;
                    $display("FAIL dogap_wr[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                             b, wr_addr[wr_base + b], wr_data[wr_base + b], b, exp_data[b]);
                end
            end
            checks++;
            if (bus.err_tmo !== 1'b0 || done_pulses - done_base != 1 || bus.frame_cnt !== 8'(exp_fc)) begin
                errors++;
                $display("FAIL dogap_done(r=%0d): got tmo %b pulses %0d cnt %0d expected 0 1 %0d",
                         r, bus.err_tmo, done_pulses - done_base, bus.frame_cnt, exp_fc);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        int k;
        int base;
        int d0;
        for (int r = 0; r < 2; r++) begin
            k    = (r == 0) ? 0 : $urandom_range(1, 10);
            base = wr_addr.size();
            d0   = done_pulses;
            bus.start     = 1'b1;
            bus.src_valid = 1'b1;
            step();
            bus.start = 1'b0;
            n = 0;
            while (bus.cbfp_di_en && n < 100) begin
                step();
                n++;
            end
            for (int c = 0; c < k; c++) begin
                bus.cbfp_do_en = 1'b1;
                bus.cbfp_index = 5'($urandom);
                step();
                bus.cbfp_do_en = 1'b0;
            end
            checks++;
            if (bus.err_tmo !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL tmo_early(k=%0d): got tmo %b busy %b expected 0 1", k, bus.err_tmo, bus.busy);
            end
            n = 0;
            while (!bus.err_tmo && n < 300) begin
                step();
                n++;
            end
            checks++;
            if (n != TMO_LAT) begin
                errors++;
                $display("FAIL tmo_latency(k=%0d): got %0d cycles expected %0d", k, n, TMO_LAT);
            end
            checks++;
            if (bus.busy !== 1'b0 || done_pulses != d0 || wr_addr.size() - base != (k + BLK - 1) / BLK) begin
                errors++;
                $display("FAIL tmo_abort(k=%0d): got busy %b pulses %0d writes %0d expected 0 0 %0d",
                         k, bus.busy, done_pulses - d0, wr_addr.size() - base, (k + BLK - 1) / BLK);
            end
            if (r == 0) begin
                bus.err_clr = 1'b1;
                step();
                bus.err_clr = 1'b0;
            end
        end
    endtask

    localparam int TMO_LAT = 127;

    task automatic test_ignore_and_reset();
        int n;
        int base;
        int d0;
        logic [4:0] v;
        base = wr_addr.size();
        d0   = done_pulses;
        bus.cbfp_do_en = 1'b1;
        repeat (4) step();
        bus.start     = 1'b1;
        bus.src_valid = 1'b1;
        step();
        n = 0;
        while (bus.cbfp_di_en && n < 100) begin
            step();
            n++;
        end
        bus.cbfp_do_en = 1'b0;
        checks++;
        if (n != FRAME || wr_addr.size() != base) begin
            errors++;
            $display("FAIL ign_feed: got feed steps %0d writes %0d expected %0d 0", n, wr_addr.size() - base, FRAME);
        end
        for (int c = 0; c < FRAME; c++) begin
            v = 5'($urandom);
            if (c % BLK == 0) exp_data[c / BLK] = v;
            bus.cbfp_do_en = 1'b1;
            bus.cbfp_index = v;
            step();
            bus.cbfp_do_en = 1'b0;
        end
        bus.start = 1'b0;
        exp_fc++;
        repeat (4) step();
        checks++;
        if (done_pulses - d0 != 1 || bus.busy !== 1'b0 || wr_addr.size() - base != NBLK
            || bus.frame_cnt !== 8'(exp_fc)) begin
            errors++;
            $display("FAIL ign_start: got pulses %0d busy %b writes %0d cnt %0d expected 1 0 %0d %0d",
                     done_pulses - d0, bus.busy, wr_addr.size() - base, bus.frame_cnt, NBLK, exp_fc);
        end
        for (int b = 0; b < NBLK && base + b < wr_addr.size(); b++) begin
            checks++;
            if (wr_addr[base + b] !== 3'(b) || wr_data[base + b] !== exp_data[b]) begin
                errors++;
                $display("FAIL ign_wr[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                         b, wr_addr[base + b], wr_data[base + b], b, exp_data[b]);
            end
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (bus.cbfp_di_en && n < 100) begin
            step();
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            bus.cbfp_do_en = 1'b1;
            bus.cbfp_index = 5'($urandom_range(1, 31));
            bus.start      = 1'b1;
            step();
            bus.cbfp_do_en = 1'b0;
            bus.start      = 1'b0;
        end
        checks++;
        if (bus.idx_we !== 1'b1 || bus.idx_addr !== 3'd1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got we %b addr %0d busy %b expected 1 1 1", bus.idx_we, bus.idx_addr, bus.busy);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.cbfp_di_en, bus.idx_we, bus.frame_done, bus.busy, bus.err_gap, bus.err_tmo} !== 6'b0
            || {bus.idx_addr, bus.idx_data, bus.frame_cnt} !== 16'h0) begin
            errors++;
            $display("FAIL rst_async: got flags %b values %h expected 0 0",
                     {bus.cbfp_di_en, bus.idx_we, bus.frame_done, bus.busy, bus.err_gap, bus.err_tmo},
                     {bus.idx_addr, bus.idx_data, bus.frame_cnt});
        end
        exp_fc = 0;
        repeat (2) step();
        rstn = 1'b1;
        base = wr_addr.size();
        d0   = done_pulses;
        repeat (40) step();
        checks++;
        if (bus.busy !== 1'b0 || done_pulses != d0 || wr_addr.size() != base || bus.frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_release: got busy %b pulses %0d writes %0d cnt %0d expected 0 0 0 0",
                     bus.busy, done_pulses - d0, wr_addr.size() - base, bus.frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int total;
        total = 0;
        for (int f = 0; f < 256; f++) begin
            run_frame(0, -1, 0, 1'b1, 1'b0);
            exp_fc++;
            total += done_pulses - done_base;
            if (f == 254) begin
                checks++;
                if (bus.frame_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255: got %0d expected 255", bus.frame_cnt);
                end
            end
        end
        checks++;
        if (bus.frame_cnt !== 8'(exp_fc) || total != 256) begin
            errors++;
            $display("FAIL wrap_0: got cnt %0d frames %0d expected %0d 256", bus.frame_cnt, total, 8'(exp_fc));
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        done_pulses = 0;
        di_pulses   = 0;
        test_reset();
        test_good_frame();
        test_gap();
        test_do_gap();
        test_timeout();
        test_ignore_and_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
